// File: rtl/zeroriscy_trace_buffer_if.sv
// zeroriscy_trace_buffer_if
//   Bundles the retire-side capture bus and the indexed readout port of the
//   trace buffer.
//   master : the core retire stage and the debug reader (drive retire_* / rd_en / rd_idx)
//   slave  : the trace buffer (returns rd_data / rd_valid)
//   Signals:
//     retire_valid, retire_pc, retire_instr, retire_rd_we, retire_rd_addr,
//     retire_rd_wdata    retired-instruction record fields
//     rd_en, rd_idx      readout request, index 0 = oldest entry
//     rd_data, rd_valid  registered readout result
interface zeroriscy_trace_buffer_if #(
    parameter int DEPTH          = 16,
    parameter int CYC_W          = 16,
    parameter int REG_ADDR_WIDTH = 5
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int REC_W = CYC_W + 97 + REG_ADDR_WIDTH;

    logic                      retire_valid;
    logic [31:0]               retire_pc;
    logic [31:0]               retire_instr;
    logic                      retire_rd_we;
    logic [REG_ADDR_WIDTH-1:0] retire_rd_addr;
    logic [31:0]               retire_rd_wdata;

    logic                      rd_en;
    logic [IDX_W-1:0]          rd_idx;
    logic [REC_W-1:0]          rd_data;
    logic                      rd_valid;

    modport master (
        output retire_valid, retire_pc, retire_instr, retire_rd_we,
               retire_rd_addr, retire_rd_wdata, rd_en, rd_idx,
        input  rd_data, rd_valid
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, retire_rd_we,
               retire_rd_addr, retire_rd_wdata, rd_en, rd_idx,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/zeroriscy_trace_buffer.sv
// zeroriscy_trace_buffer
//   On-chip instruction trace capture for zero-riscy. Retired instructions are
//   written into a DEPTH-entry circular buffer; capture modes are continuous
//   (0, 3), one-shot (1) and PC trigger with a POST_TRIG-record tail (2).
//   Ports:
//     clk, rst_n        core clock, asynchronous active-low reset
//     arm, stop         start capture (from IDLE/FROZEN) / abort to IDLE (wins)
//     mode              capture mode, latched on arm
//     trig_pc           trigger PC for mode 2
//     filt_lo, filt_hi  inclusive PC filter window (TRACE_PC_FILTER_EN only)
//     bus               retire record input and indexed readout (slave modport)
//     state             IDLE=0, CAPTURE=1, POST=2, FROZEN=3
//     count             valid entries, saturating at DEPTH
//     wrapped           at least one entry has been overwritten
//   Record layout, pc in the LSBs: {cyc, rd_we, rd_addr, rd_wdata, instr, pc};
//   rd_data is as wide as the sum of those fields.
//   Optional feature: define TRACE_PC_FILTER_EN to capture only retirements
//   whose PC lies within [filt_lo, filt_hi].
module zeroriscy_trace_buffer #(
    parameter int DEPTH          = 16,
    parameter int CYC_W          = 16,
    parameter int POST_TRIG      = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [31:0]            trig_pc,
    input  logic [31:0]            filt_lo,
    input  logic [31:0]            filt_hi,
    zeroriscy_trace_buffer_if.slave bus,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   wrapped
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int REC_W = CYC_W + 97 + REG_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_FROZEN  = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   count_q;
    logic             wrapped_q;
    logic [CYC_W-1:0] cyc_q;
    logic [IDX_W-1:0] post_q;

    logic [REC_W-1:0] mem [DEPTH];

    logic             active;
    logic             filt_ok;
    logic             cap;
    logic [REC_W-1:0] rec;
    logic [IDX_W-1:0] slot;

`ifdef TRACE_PC_FILTER_EN
    assign filt_ok = (bus.retire_pc >= filt_lo) && (bus.retire_pc <= filt_hi);
`else
    assign filt_ok = 1'b1;
    logic unused_filt;
    assign unused_filt = ^{filt_lo, filt_hi};
`endif

    assign active = (state_q == S_CAPTURE) || (state_q == S_POST);
    // stop takes the whole edge: nothing is recorded on the abort cycle
    assign cap    = bus.retire_valid && active && filt_ok && !stop;
    assign rec    = {cyc_q, bus.retire_rd_we, bus.retire_rd_addr,
                     bus.retire_rd_wdata, bus.retire_instr, bus.retire_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            wr_ptr    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            cyc_q     <= '0;
            post_q    <= '0;
        end else if (stop) begin
            state_q <= S_IDLE;
        end else if (arm && !active) begin
            state_q   <= S_CAPTURE;
            mode_q    <= mode;
            wr_ptr    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            cyc_q     <= '0;
        end else if (active) begin
            if (cyc_q != {CYC_W{1'b1}})
                cyc_q <= cyc_q + 1'b1;
            if (cap) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count_q != (IDX_W+1)'(DEPTH))
                    count_q <= count_q + 1'b1;
                if (wr_ptr == IDX_W'(DEPTH-1))
                    wrapped_q <= 1'b1;
                if (state_q == S_CAPTURE) begin
                    if (mode_q == 2'd1 && count_q == (IDX_W+1)'(DEPTH-1))
                        state_q <= S_FROZEN;
                    if (mode_q == 2'd2 && bus.retire_pc == trig_pc) begin
                        post_q  <= IDX_W'(POST_TRIG);
                        state_q <= (POST_TRIG == 0) ? S_FROZEN : S_POST;
                    end
                end else begin
                    // POST: this capture is the last of the tail when the counter hits 0
                    post_q <= post_q - 1'b1;
                    if (post_q == IDX_W'(1))
                        state_q <= S_FROZEN;
                end
            end
        end
    end

    // Record storage has no reset; contents survive reset and stop.
    always_ff @(posedge clk) begin
        if (cap)
            mem[wr_ptr] <= rec;
    end

    // Once wrapped, the oldest entry sits at the write pointer.
    assign slot = wrapped_q ? (wr_ptr + bus.rd_idx) : bus.rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else if (bus.rd_en) begin
            if ({1'b0, bus.rd_idx} < count_q) begin
                bus.rd_valid <= 1'b1;
                bus.rd_data  <= mem[slot];
            end else begin
                bus.rd_valid <= 1'b0;
                bus.rd_data  <= '0;
            end
        end else begin
            bus.rd_valid <= 1'b0;
        end
    end

    assign state   = state_q;
    assign count   = count_q;
    assign wrapped = wrapped_q;
endmodule

// File: tb/tb_zeroriscy_trace_buffer.sv
module tb_zeroriscy_trace_buffer;
    localparam int DEPTH = 8;
    localparam int CYC_W = 16;
    localparam int RAW   = 5;
    localparam int REC_W = CYC_W + 97 + RAW;

    localparam logic [REC_W-1:0] ALL_M    = {REC_W{1'b1}};
    localparam logic [REC_W-1:0] PC_M     = REC_W'(32'hFFFF_FFFF);
    localparam logic [REC_W-1:0] CYC_PC_M = (ALL_M << (REC_W - CYC_W)) | PC_M;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] trig_pc = 32'h0;
    logic [31:0] filt_lo = 32'h0;
    logic [31:0] filt_hi = 32'hFFFF_FFFF;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        wrapped;

    zeroriscy_trace_buffer_if #(.DEPTH(DEPTH), .CYC_W(CYC_W), .REG_ADDR_WIDTH(RAW)) bus ();

    zeroriscy_trace_buffer #(
        .DEPTH(DEPTH), .CYC_W(CYC_W), .POST_TRIG(2), .REG_ADDR_WIDTH(RAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .mode(mode),
        .trig_pc(trig_pc), .filt_lo(filt_lo), .filt_hi(filt_hi),
        .bus(bus), .state(state), .count(count), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             v;
        logic [REC_W-1:0] d;
        logic [REC_W-1:0] m;
        string            name;
    } exp_t;
    exp_t sbq[$];

    // Reference record for a retirement of pc with timestamp cyc
    function automatic logic [REC_W-1:0] mkrec(input logic [15:0] cyc, input logic [31:0] pc);
        return {cyc, 1'b1, pc[6:2], ~pc, {pc[15:0], 16'h0013}, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic retire(input logic [31:0] pc);
        bus.retire_valid    = 1'b1;
        bus.retire_pc       = pc;
        bus.retire_instr    = {pc[15:0], 16'h0013};
        bus.retire_rd_we    = 1'b1;
        bus.retire_rd_addr  = pc[6:2];
        bus.retire_rd_wdata = ~pc;
        tick();
        bus.retire_valid    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] idx, input logic v,
                      input logic [REC_W-1:0] d, input logic [REC_W-1:0] m);
        exp_t e;
        e.v = v; e.d = d; e.m = m; e.name = name;
        sbq.push_back(e);
        bus.rd_en  = 1'b1;
        bus.rd_idx = idx;
        tick();
        bus.rd_en  = 1'b0;
    endtask

    task automatic arm_mode(input logic [1:0] m);
        mode = m;
        arm  = 1'b1;
        tick();
        arm  = 1'b0;
    endtask

    // Monitor: one response is due on the falling edge after each sampled rd_en
    logic rd_pend = 1'b0;
    always @(posedge clk) rd_pend <= bus.rd_en;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: response with empty scoreboard");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (bus.rd_valid !== e.v || (bus.rd_data & e.m) !== (e.d & e.m)) begin
                    errors++;
                    $display("FAIL %s: rd_valid=%0b rd_data=%h, expected rd_valid=%0b rd_data=%h (mask %h)",
                             e.name, bus.rd_valid, bus.rd_data & e.m, e.v, e.d & e.m, e.m);
                end
            end
        end else if (rst_n && bus.rd_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_idle: got %b, expected 0", bus.rd_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.retire_valid    = 1'b0;
        bus.retire_pc       = '0;
        bus.retire_instr    = '0;
        bus.retire_rd_we    = 1'b0;
        bus.retire_rd_addr  = '0;
        bus.retire_rd_wdata = '0;
        bus.rd_en           = 1'b0;
        bus.rd_idx          = '0;

        // Reset values
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_wrapped", 32'(wrapped), 32'd0);
        rd("reset_read", 3'd0, 1'b0, '0, ALL_M);

        // Mode 0: 11 retires wrap an 8-deep buffer; oldest is k=3
        arm_mode(2'd0);
        chk("m0_state", 32'(state), 32'd1);
        for (int k = 0; k <= 10; k++) retire(32'h100 + 32'(4*k));
        chk("m0_count", 32'(count), 32'd8);
        chk("m0_wrapped", 32'(wrapped), 32'd1);
        rd("m0_idx0", 3'd0, 1'b1, mkrec(16'd3, 32'h10C), ALL_M);
        rd("m0_idx7", 3'd7, 1'b1, mkrec(16'd10, 32'h128), ALL_M);
        arm_mode(2'd1);
        chk("m0_arm_ignored_count", 32'(count), 32'd8);
        chk("m0_arm_ignored_state", 32'(state), 32'd1);

        // stop keeps contents and count
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_count", 32'(count), 32'd8);

        // Mode 1: freezes on the 8th capture
        arm_mode(2'd1);
        for (int k = 0; k < 8; k++) retire(32'h300 + 32'(4*k));
        chk("m1_frozen", 32'(state), 32'd3);
        retire(32'h320);
        retire(32'h324);
        chk("m1_count", 32'(count), 32'd8);
        chk("m1_wrapped", 32'(wrapped), 32'd1);
        rd("m1_idx0", 3'd0, 1'b1, mkrec(16'd0, 32'h300), ALL_M);
        rd("m1_idx7", 3'd7, 1'b1, mkrec(16'd7, 32'h31C), ALL_M);

        // Mode 2: trigger at 0x200, two-record tail
        trig_pc = 32'h200;
        arm_mode(2'd2);
        chk("rearm_count", 32'(count), 32'd0);
        chk("rearm_wrapped", 32'(wrapped), 32'd0);
        retire(32'h1F8);
        retire(32'h1FC);
        retire(32'h200);
        chk("m2_post", 32'(state), 32'd2);
        retire(32'h204);
        chk("m2_post_mid", 32'(state), 32'd2);
        retire(32'h208);
        chk("m2_frozen", 32'(state), 32'd3);
        retire(32'h20C);
        chk("m2_count", 32'(count), 32'd5);
        rd("m2_idx0", 3'd0, 1'b1, mkrec(16'd0, 32'h1F8), ALL_M);
        rd("m2_idx2", 3'd2, 1'b1, mkrec(16'd2, 32'h200), ALL_M);
        rd("m2_idx4", 3'd4, 1'b1, mkrec(16'd4, 32'h208), ALL_M);
        rd("m2_idx5_oob", 3'd5, 1'b0, '0, ALL_M);

        // Timestamps with gaps: cyc 0, 3, 6
        arm_mode(2'd0);
        retire(32'h400);
        tick(); tick();
        retire(32'h404);
        tick(); tick();
        retire(32'h408);
        rd("cyc_idx0", 3'd0, 1'b1, mkrec(16'd0, 32'h400), CYC_PC_M);
        rd("cyc_idx1", 3'd1, 1'b1, mkrec(16'd3, 32'h404), CYC_PC_M);
        rd("cyc_idx2", 3'd2, 1'b1, mkrec(16'd6, 32'h408), CYC_PC_M);
        stop = 1'b1; arm = 1'b1;
        tick();
        stop = 1'b0; arm = 1'b0;
        chk("stop_wins_state", 32'(state), 32'd0);
        chk("stop_wins_count", 32'(count), 32'd3);

        // PC filter window
        filt_lo = 32'h100;
        filt_hi = 32'h1FF;
        arm_mode(2'd0);
        retire(32'h0FC);
        retire(32'h100);
        retire(32'h200);
        retire(32'h1FC);
`ifdef TRACE_PC_FILTER_EN
        chk("filt_count", 32'(count), 32'd2);
        rd("filt_idx0", 3'd0, 1'b1, mkrec(16'd0, 32'h100), PC_M);
        rd("filt_idx1", 3'd1, 1'b1, mkrec(16'd0, 32'h1FC), PC_M);
        rd("filt_idx2_oob", 3'd2, 1'b0, '0, ALL_M);
`else
        chk("nofilt_count", 32'(count), 32'd4);
        rd("nofilt_idx1", 3'd1, 1'b1, mkrec(16'd1, 32'h100), CYC_PC_M);
        rd("nofilt_idx3", 3'd3, 1'b1, mkrec(16'd3, 32'h1FC), CYC_PC_M);
`endif

        // Reset in the middle of a capture
        retire(32'h500);
        rst_n = 1'b0;
        #2;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_wrapped", 32'(wrapped), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd("midrst_read", 3'd0, 1'b0, '0, ALL_M);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d reads still pending, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
